pwm_top: RTL and testbench
==========================

// Module: pwm_top
// PURPOSE
//   Single-channel PWM generator for the CPU peripheral bus.
//   A programmable prescaler divides the system clock into step ticks; a 100-step counter
//   compares against a duty value (percent) to drive pwm_clk.
//   Control values come from software-written registers upstream and are sampled glitch-free
//   at period boundaries.
// PARAMETERS
//   SYS_CLK       100_000_000  system clock frequency in Hz; informational, no effect on logic
//   PERIOD_STEPS  100          steps per PWM period (duty resolution); fixed at 100 in pwm_pkg
// PORTS
//   clk         in   1   system clock; all logic on rising edge
//   reset       in   1   synchronous, active-high reset
//   prescaler   in   32  clk cycles per PWM step; 0 is treated as 1
//   duty_cycle  in   32  high steps per period (0..100); values >100 are clamped to 100
//   pwm_clk     out  1   registered PWM output
//   One clock; reset is synchronous and active-high.
// BEHAVIOUR
//   Registers: pre_cnt[31:0], step_cnt[6:0], presc_q[31:0], duty_q[6:0], pwm_clk.
//   Reset (sampled high on an edge):
//     - pre_cnt=0, step_cnt=0, pwm_clk=0.
//     - presc_q=max(prescaler,1), duty_q=min(duty_cycle,100); loaded every reset cycle.
//   Running, per clk edge:
//     - P=presc_q. tick = (pre_cnt==P-1).
//     - pre_cnt <= tick ? 0 : pre_cnt+1.
//     - On tick: step_cnt <= (step_cnt==99) ? 0 : step_cnt+1.
//     - On tick with step_cnt==99 (period end): reload presc_q and duty_q from the inputs
//       (same clamping as at reset). This is the only point where input changes take effect;
//       mid-period input changes are ignored until then.
//     - pwm_clk <= (step_cnt < duty_q), using current pre-edge register values.
//       This gives 1-cycle output latency.
//   Timing:
//     - Period = 100*P clk cycles; high time = duty_q*P cycles, contiguous from period start.
//     - First edge after reset release drives pwm_clk=1 if duty_q>0.
//   Boundaries:
//     - duty_q=0: pwm_clk constantly 0. duty_q=100: constantly 1, no glitch at wrap.
//     - P=1: step advances every cycle, period 100 cycles.
//     - P=2^32-1: pre_cnt must not overflow, so the compare is done in 32 bits.
//     - Reset asserted mid-period: pwm_clk=0 and counters=0 after that edge.
//       Reset has priority over tick/reload on the same edge.
// STRUCTURE
//   pwm_pkg:
//     - localparam PERIOD_STEPS=100, STEP_W=7, CFG_W=32.
//     - Clamp functions clamp_presc() and clamp_duty().
//   Sub-module pwm_prescaler (clk, reset, presc, tick): owns pre_cnt and the tick output.
//   Top level holds the step counter, shadow registers, compare and output flop.
// TESTING
//   1. reset 1 cycle, prescaler=100, duty=30
//      -> pwm_clk high 3000 cycles, low 7000, period 10000, repeating.
//   2. prescaler=1, duty=50 -> 50 high / 50 low; prescaler=0 gives the identical waveform.
//   3. duty=0 -> pwm_clk never high; duty=100 and duty=250 -> pwm_clk constantly 1 after reset.
//   4. prescaler=10, duty=20; change duty to 70 at step 40
//      -> current period keeps 200 high; next period 700 high of 1000.
//   5. reset pulsed mid-high phase -> pwm_clk 0 on that edge; restart is identical to
//      a fresh start.
//   6. Self-checking monitor: measure every period's high and low counts against
//      duty_q*P and (100-duty_q)*P; any mismatch fails.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and input-clamping helpers for the single-channel PWM generator.
package pwm_pkg;

   localparam int unsigned PERIOD_STEPS = 100;
   localparam int unsigned STEP_W       = 7;
   localparam int unsigned CFG_W        = 32;

   localparam logic [STEP_W-1:0] LAST_STEP = 7'd99;
   localparam logic [STEP_W-1:0] MAX_DUTY  = 7'd100;

   function automatic logic [CFG_W-1:0] clamp_presc(input logic [CFG_W-1:0] presc);
      logic [CFG_W-1:0] res;
      if (presc == 32'd0) begin
         res = 32'd1;
      end else begin
         res = presc;
      end
      return res;
   endfunction

   function automatic logic [STEP_W-1:0] clamp_duty(input logic [CFG_W-1:0] duty);
      logic [STEP_W-1:0] res;
      if (duty > 32'd100) begin
         res = MAX_DUTY;
      end else begin
         res = duty[STEP_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the system clock into step ticks: tick is high on the last cycle of every presc-cycle window.
module pwm_prescaler
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CFG_W-1:0] presc,
   output logic             tick
);

   logic [CFG_W-1:0] pre_cnt_q;
   logic [CFG_W-1:0] pre_cnt_d;

   // presc is never 0 (clamped upstream), so the full-width compare cannot underflow
   assign tick = (pre_cnt_q == (presc - 32'd1));

   // Next prescaler count
   always_comb begin
      pre_cnt_d = pre_cnt_q;
      if (tick) begin
         pre_cnt_d = 32'd0;
      end else begin
         pre_cnt_d = pre_cnt_q + 32'd1;
      end
   end

   // Prescaler count register
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_q <= 32'd0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/pwm_top.sv
// Single-channel PWM: 100-step counter compared against a shadowed duty value,
// with prescaler and duty shadows reloaded only at period boundaries.
module pwm_top
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CFG_W-1:0] prescaler,
   input  logic [CFG_W-1:0] duty_cycle,
   output logic             pwm_clk
);

   logic [CFG_W-1:0]  presc_q;
   logic [CFG_W-1:0]  presc_d;
   logic [STEP_W-1:0] duty_q;
   logic [STEP_W-1:0] duty_d;
   logic [STEP_W-1:0] step_q;
   logic [STEP_W-1:0] step_d;
   logic              pwm_q;
   logic              pwm_d;
   logic              tick_s;
   logic              period_end_s;

   pwm_prescaler u_prescaler (
      .clk   (clk),
      .reset (reset),
      .presc (presc_q),
      .tick  (tick_s)
   );

   assign period_end_s = tick_s && (step_q == LAST_STEP);

   // Step counter, shadow reload at period end, and output compare
   always_comb begin
      step_d  = step_q;
      presc_d = presc_q;
      duty_d  = duty_q;
      if (period_end_s) begin
         step_d  = 7'd0;
         presc_d = clamp_presc(prescaler);
         duty_d  = clamp_duty(duty_cycle);
      end else if (tick_s) begin
         step_d = step_q + 7'd1;
      end else begin
         step_d = step_q;
      end
      pwm_d = (step_q < duty_q);
   end

   // State registers; shadows track the inputs for as long as reset is held
   always_ff @(posedge clk) begin
      if (reset) begin
         step_q  <= 7'd0;
         pwm_q   <= 1'b0;
         presc_q <= clamp_presc(prescaler);
         duty_q  <= clamp_duty(duty_cycle);
      end else begin
         step_q  <= step_d;
         pwm_q   <= pwm_d;
         presc_q <= presc_d;
         duty_q  <= duty_d;
      end
   end

   assign pwm_clk = pwm_q;

endmodule

// File: tb/tb_pwm_top.sv
// Scoreboard bench for pwm_top: expected high/low run lengths are queued by the stimulus,
// and a negedge monitor measures each completed run of pwm_clk and compares.
module tb_pwm_top;

   typedef struct {
      logic level;
      int   len;
   } run_t;

   logic        clk;
   logic        reset;
   logic [31:0] prescaler;
   logic [31:0] duty_cycle;
   logic        pwm_clk;

   run_t exp_q[$];
   int   n_tests;
   int   n_fail;
   int   run_idx;
   logic mon_en;
   logic mon_started;
   logic mon_level;
   int   mon_len;
   int   hi_cnt;
   int   lo_cnt;

   pwm_top dut (
      .clk        (clk),
      .reset      (reset),
      .prescaler  (prescaler),
      .duty_cycle (duty_cycle),
      .pwm_clk    (pwm_clk)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: measure each completed constant run of pwm_clk and check it against the queue
   always @(negedge clk) begin
      if (!mon_en) begin
         mon_started = 1'b0;
         mon_len     = 0;
         hi_cnt      = 0;
         lo_cnt      = 0;
      end else begin
         if (pwm_clk === 1'b1) hi_cnt = hi_cnt + 1;
         else                  lo_cnt = lo_cnt + 1;
         if (!mon_started) begin
            mon_started = 1'b1;
            mon_level   = pwm_clk;
            mon_len     = 1;
         end else if (pwm_clk === mon_level) begin
            mon_len = mon_len + 1;
         end else begin
            if (exp_q.size() > 0) begin
               run_t e;
               e = exp_q.pop_front();
               n_tests = n_tests + 1;
               run_idx = run_idx + 1;
               if (e.level !== mon_level || e.len != mon_len) begin
                  n_fail = n_fail + 1;
                  $display("FAIL run%0d: got level=%0b len=%0d, expected level=%0b len=%0d",
                           run_idx, mon_level, mon_len, e.level, e.len);
               end
            end
            mon_level = pwm_clk;
            mon_len   = 1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests = n_tests + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_period(input int hi, input int lo, input int periods);
      run_t r;
      for (int i = 0; i < periods; i++) begin
         r.level = 1'b1; r.len = hi; exp_q.push_back(r);
         r.level = 1'b0; r.len = lo; exp_q.push_back(r);
      end
   endtask

   // One reset edge, then enable the monitor so its first sample is the first running output
   task automatic do_reset(input logic [31:0] p, input logic [31:0] d);
      mon_en     = 1'b0;
      prescaler  = p;
      duty_cycle = d;
      reset      = 1'b1;
      @(posedge clk); #1;
      check("pwm_after_reset_edge", int'(pwm_clk), 0);
      reset = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
   endtask

   task automatic wait_drain(input string name, input int bound);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < bound) begin
         @(posedge clk);
         c = c + 1;
      end
      #1;
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      run_idx    = 0;
      mon_en     = 1'b0;
      reset      = 1'b1;
      prescaler  = 32'd100;
      duty_cycle = 32'd30;
      repeat (2) @(posedge clk);
      #1;

      // 1: P=100, duty 30 -> 3000 high / 7000 low
      push_period(3000, 7000, 2);
      do_reset(32'd100, 32'd30);
      wait_drain("t1_drain", 25000);

      // 2: P=1 and P=0 give identical 50/50 waveforms
      push_period(50, 50, 2);
      do_reset(32'd1, 32'd50);
      wait_drain("t2_p1_drain", 400);
      push_period(50, 50, 2);
      do_reset(32'd0, 32'd50);
      wait_drain("t2_p0_drain", 400);

      // 3: duty 0 never high; duty 100 and 250 always high across several wraps
      do_reset(32'd1, 32'd0);
      repeat (300) @(posedge clk);
      #1;
      check("t3_duty0_high_cycles", hi_cnt, 0);
      do_reset(32'd1, 32'd100);
      repeat (300) @(posedge clk);
      #1;
      check("t3_duty100_low_cycles", lo_cnt, 0);
      do_reset(32'd1, 32'd250);
      repeat (300) @(posedge clk);
      #1;
      check("t3_duty250_low_cycles", lo_cnt, 0);

      // 4: duty change mid-period only takes effect at the next period
      exp_q.push_back('{1'b1, 200});
      exp_q.push_back('{1'b0, 800});
      exp_q.push_back('{1'b1, 700});
      exp_q.push_back('{1'b0, 300});
      do_reset(32'd10, 32'd20);
      repeat (400) @(posedge clk);
      #1;
      duty_cycle = 32'd70;
      wait_drain("t4_drain", 3000);

      // 5: reset in the middle of the high phase, then a clean restart
      do_reset(32'd10, 32'd50);
      repeat (200) @(posedge clk);
      #1;
      check("t5_high_before_reset", int'(pwm_clk), 1);
      push_period(500, 500, 2);
      do_reset(32'd10, 32'd50);
      wait_drain("t5_drain", 3000);

      mon_en = 1'b0;
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
